// File: rtl/memory_access.sv
// MEM-stage data-memory access unit: runs one load/store over a req/gnt/rvalid bus,
// stalls the pipeline until it completes, registers load data and resolves PCSrc_M.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic        Branch_M,
  input  logic        zero_M,
  input  logic [63:0] aluResult_M,
  input  logic [63:0] writeData_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic        stall_M,
  output logic [63:0] readData_M,
  output logic        PCSrc_M,
  output logic        mem_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          we_reg;
  logic [63:0]   addr_reg;
  logic [63:0]   wdata_reg;
  logic [63:0]   read_data_reg;
  logic          mem_error_reg;

  logic acc, bad, start, timeout, load_done;

  assign acc = valid_M & (MemRead_M ^ MemWrite_M);
  assign bad = valid_M & ((MemRead_M & MemWrite_M) |
                          ((MemRead_M | MemWrite_M) & (aluResult_M[2:0] != 3'd0)));

  always_comb begin
    state_next = state_reg;
    stall_M    = 1'b0;
    start      = 1'b0;
    timeout    = 1'b0;
    load_done  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        start   = acc & ~bad;
        stall_M = start;
        if (start) state_next = REQ;
      end
      REQ: begin
        stall_M = 1'b1;
        // A store completes on grant; a load still has to wait for its data.
        if (dmem_gnt && we_reg) begin
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end else if (dmem_gnt) begin
          state_next = RESP;
        end
      end
      RESP: begin
        stall_M = 1'b1;
        if (dmem_rvalid) begin
          load_done  = 1'b1;
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      read_data_reg <= '0;
      mem_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        addr_reg  <= aluResult_M;
        wdata_reg <= writeData_M;
        we_reg    <= MemWrite_M;
        cnt_reg   <= '0;
      end else if (state_reg == REQ || state_reg == RESP) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((state_reg == IDLE && bad) || timeout) mem_error_reg <= 1'b1;
      if (timeout) read_data_reg <= '0;
      else if (load_done) read_data_reg <= dmem_rdata;
    end
  end

  assign dmem_req   = (state_reg == REQ);
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign readData_M = read_data_reg;
  assign mem_error  = mem_error_reg;
  assign PCSrc_M    = valid_M & Branch_M & zero_M;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: stores, loads with wait states, misaligned and
// conflicting requests, timeout, reset mid-access and the branch decision.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M, MemRead_M, MemWrite_M, Branch_M, zero_M;
  logic [63:0] aluResult_M, writeData_M;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        stall_M;
  logic [63:0] readData_M;
  logic        PCSrc_M, mem_error;

  int vecs = 0;
  int errs = 0;
  int stalls;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .MemRead_M(MemRead_M),
    .MemWrite_M(MemWrite_M), .Branch_M(Branch_M), .zero_M(zero_M),
    .aluResult_M(aluResult_M), .writeData_M(writeData_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .stall_M(stall_M), .readData_M(readData_M),
    .PCSrc_M(PCSrc_M), .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vecs, tag, obs, exp);
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; valid_M = 0; MemRead_M = 0; MemWrite_M = 0; Branch_M = 0; zero_M = 0;
    aluResult_M = '0; writeData_M = '0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 64'h0);
    chk("rst_wdata", dmem_wdata, 64'h0);
    chk("rst_stall", stall_M, 1'b0);
    chk("rst_rdata", readData_M, 64'h0);
    chk("rst_err", mem_error, 1'b0);

    // 1: store, granted on first REQ cycle
    tick();
    valid_M = 1; MemWrite_M = 1; aluResult_M = 64'h10; writeData_M = 64'hDEADBEEF;
    #1 chk("st_idle_stall", stall_M, 1'b1);
    chk("st_idle_req", dmem_req, 1'b0);
    tick();
    dmem_gnt = 1;
    #1 chk("st_req", dmem_req, 1'b1);
    chk("st_we", dmem_we, 1'b1);
    chk("st_addr", dmem_addr, 64'h10);
    chk("st_wdata", dmem_wdata, 64'hDEADBEEF);
    chk("st_req_stall", stall_M, 1'b1);
    tick();
    dmem_gnt = 0; valid_M = 0; MemWrite_M = 0;
    #1 chk("st_done_stall", stall_M, 1'b0);
    chk("st_done_req", dmem_req, 1'b0);

    // 2: load, two wait states before grant, data one cycle after grant
    tick();
    stalls = 0;
    valid_M = 1; MemRead_M = 1; aluResult_M = 64'h20;
    #1 stalls += int'(stall_M);
    for (int i = 0; i < 3; i++) begin
      tick();
      dmem_gnt = (i == 2);
      #1 stalls += int'(stall_M);
      chk("ld_req", dmem_req, 1'b1);
    end
    chk("ld_we", dmem_we, 1'b0);
    chk("ld_addr", dmem_addr, 64'h20);
    tick();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 64'h1234;
    #1 stalls += int'(stall_M);
    chk("ld_resp_req", dmem_req, 1'b0);
    tick();
    dmem_rvalid = 0; dmem_rdata = '0; valid_M = 0; MemRead_M = 0;
    #1 stalls += int'(stall_M);
    chk("ld_done_stall", stall_M, 1'b0);
    chk("ld_rdata", readData_M, 64'h1234);
    chk("ld_stall_cycles", 64'(stalls), 64'd5);

    // 4: timeout on an ungranted load
    tick();
    valid_M = 1; MemRead_M = 1; aluResult_M = 64'h40;
    #1 chk("to_idle_stall", stall_M, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("to_req", dmem_req, 1'b1);
    end
    chk("to_err_before", mem_error, 1'b0);
    tick();
    valid_M = 0; MemRead_M = 0;
    #1 chk("to_done_req", dmem_req, 1'b0);
    chk("to_done_stall", stall_M, 1'b0);
    chk("to_err", mem_error, 1'b1);
    chk("to_rdata", readData_M, 64'h0);

    // reset clears the sticky error
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1 chk("rst2_err", mem_error, 1'b0);

    // 3: misaligned load, then read+write conflict
    tick();
    valid_M = 1; MemRead_M = 1; aluResult_M = 64'h13;
    #1 chk("mis_stall", stall_M, 1'b0);
    chk("mis_req", dmem_req, 1'b0);
    tick();
    MemWrite_M = 1; aluResult_M = 64'h18;
    #1 chk("mis_err", mem_error, 1'b1);
    chk("rw_stall", stall_M, 1'b0);
    chk("rw_req", dmem_req, 1'b0);
    tick();
    valid_M = 0; MemRead_M = 0; MemWrite_M = 0;
    #1 chk("rw_req2", dmem_req, 1'b0);
    tick();
    #1 chk("err_sticky", mem_error, 1'b1);

    // 5: reset during RESP, late rvalid afterwards ignored
    tick();
    valid_M = 1; MemRead_M = 1; aluResult_M = 64'h30;
    tick();
    dmem_gnt = 1;
    #1 chk("rr_req", dmem_req, 1'b1);
    tick();
    dmem_gnt = 0; reset = 1;
    #1 chk("rr_resp_stall", stall_M, 1'b1);
    tick();
    reset = 0; valid_M = 0; MemRead_M = 0; dmem_rvalid = 1; dmem_rdata = 64'hFFFF;
    #1 chk("rr_req_after", dmem_req, 1'b0);
    chk("rr_stall_after", stall_M, 1'b0);
    tick();
    dmem_rvalid = 0; dmem_rdata = '0;
    #1 chk("rr_rdata", readData_M, 64'h0);
    chk("rr_stall2", stall_M, 1'b0);
    chk("rr_err", mem_error, 1'b0);

    // 6: branch decision
    valid_M = 1; Branch_M = 1; zero_M = 1;
    #1 chk("br_taken", PCSrc_M, 1'b1);
    zero_M = 0;
    #1 chk("br_nz", PCSrc_M, 1'b0);
    valid_M = 0; zero_M = 1;
    #1 chk("br_invalid", PCSrc_M, 1'b0);
    Branch_M = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
